bus_responder: RTL
==================

// Module: bus_responder
// PURPOSE
//  Bus-side counterpart to the 65C02 core: decodes AD/WE/DO, returns read data on DI one cycle
//  after the address (synchronous-memory timing), and drives RDY, IRQ and NMI back to the core.
//  Contains a byte RAM, an 8-register I/O page with a 16-bit interval timer, and a wait-state FSM.
// PARAMETERS
//  RAM_AW   12     RAM address width; RAM occupies 0 .. 2**RAM_AW-1
//  IO_PAGE  8'hFE  AD[15:8] value selecting the I/O page (overrides RAM on overlap)
//  IO_WAIT  2      RDY-low cycles inserted after each I/O read (0 = none)
//  NMI_LEN  4      cycles NMI is held high after a write to NMITRG
// PORTS
//  clk    in   1   clock, all state on rising edge
//  RST_N  in   1   reset, asynchronous, active-low
//  AD     in   16  address from core (combinational on core side)
//  WE     in   1   write enable from core
//  DO     in   8   write data from core
//  DI     out  8   read data to core, registered
//  RDY    out  1   ready to core; 0 freezes core, registered
//  IRQ    out  1   level interrupt request, registered
//  NMI    out  1   non-maskable request pulse, registered
// BEHAVIOUR
//  Reset: DI=8'h00, RDY=1, IRQ=0, NMI=0, all I/O regs 0, FSM=IDLE. RAM contents not reset.
//  Reset asserted mid-wait: RDY returns to 1 immediately, pending access discarded.
//  Access sampling: AD/WE/DO captured only at edges with RDY=1; with RDY=0 nothing is sampled,
//   DI holds. Reads: DI <= data(AD) at that edge (latency 1). Writes: committed at that edge,
//   DI unchanged.
//  Decode: AD[15:8]==IO_PAGE -> I/O reg AD[2:0] (AD[7:3] ignored); AD < 2**RAM_AW -> RAM;
//   else unmapped: reads 8'hFF, writes dropped.
//  I/O map: 0 CNTLO  R current count[7:0]; W reload_lo
//           1 CNTHI  R current count[15:8]; W reload_hi, count <= {DO, reload_lo}
//           2 CTRL   RW bit0 EN, bit1 IRQEN, bit2 AUTO, bit3 NMISEL (see CONFIGURATION), [7:4]=0
//           3 STAT   R bit0 EXP; W bit0=1 clears EXP (write-1-to-clear)
//           4 NMITRG W any -> NMI=1 for NMI_LEN cycles; R 8'h00
//           5..7     R 8'h00, writes ignored
//  Timer: EN=1 -> count decrements every clk (independent of RDY). On count==1->0 edge: EXP<=1;
//   if AUTO count<={reload_hi,reload_lo} next cycle, else EN<=0 and count stays 0.
//   count==0 with EN=1 written: expires next edge (0 treated as 1). 16-bit, no underflow wrap.
//   EXP set and W1C on the same edge: set wins. CNTHI write and expiry same edge: write wins, no EXP.
//  IRQ <= EXP & IRQEN (level until cleared or disabled).
//  NMI: retrigger while high restarts NMI_LEN count; NMI_LEN=0 -> no pulse.
//  Wait FSM: IDLE --(I/O read sampled, IO_WAIT>0)--> WAIT: RDY<=0, cnt<=IO_WAIT-1;
//   WAIT: cnt decrements, at cnt==0 RDY<=1 -> IDLE. DI carries the I/O data throughout.
//   Net: I/O read occupies 1+IO_WAIT core cycles. RAM, unmapped and all writes: zero waits.
//   Back-to-back I/O reads each insert IO_WAIT cycles.
// CONFIGURATION
//  WAIT_STATES_EN defined: wait FSM as above. Undefined: RDY tied to 1, IO_WAIT ignored, FSM absent.
//  CTRL bit3 NMISEL: when 1, timer expiry also fires an NMI_LEN NMI pulse; always present.
// TESTING
//  1 Write 8'hA5 to 16'h0010, read 16'h0010 -> DI=8'hA5 one cycle after read address, RDY=1.
//  2 Read 16'hFE03 with WAIT_STATES_EN, IO_WAIT=2 -> RDY low exactly 2 cycles, DI=8'h00,
//    core AD frozen; without macro RDY stays 1.
//  3 reload=16'h0003, CTRL=8'h07 -> EXP/IRQ set 3 cycles after CNTHI write, count reloads to 3,
//    repeats every 3 cycles; write 8'h01 to STAT -> IRQ drops next cycle.
//  4 W1C to STAT on the same edge as expiry -> EXP remains 1.
//  5 Write NMITRG, NMI_LEN=4 -> NMI high 4 cycles; rewrite at cycle 2 -> high 6 cycles total.
//  6 Assert RST_N=0 during WAIT -> RDY=1, IRQ=0, NMI=0, DI=8'h00 immediately; read 16'hC000 -> 8'hFF.

Source files
------------

// File: rtl/bus_responder.sv
// Bus-side responder for a 65C02 core: byte RAM, 8-register I/O page with interval timer, NMI pulser.
// Define WAIT_STATES_EN to build the wait-state FSM that stalls the core (RDY low) after I/O reads.
module bus_responder #(
    parameter int unsigned RAM_AW  = 12,
    parameter logic [7:0]  IO_PAGE = 8'hFE,
    parameter int unsigned IO_WAIT = 2,
    parameter int unsigned NMI_LEN = 4
) (
    input  logic        clk,
    input  logic        RST_N,
    input  logic [15:0] AD,
    input  logic        WE,
    input  logic [7:0]  DO,
    output logic [7:0]  DI,
    output logic        RDY,
    output logic        IRQ,
    output logic        NMI
);

    localparam int unsigned NCW = (NMI_LEN > 0) ? $clog2(NMI_LEN + 1) : 1;

    logic        rdy;
    logic        io_hit;
    logic        ram_hit;
    logic        rd_acc;
    logic        wr_acc;
    logic [2:0]  io_idx;
    logic [4:0]  io_wr;
    logic [7:0]  io_rdata;

    // Address decode; the I/O page wins over RAM when both match.
    assign io_idx  = AD[2:0];
    assign io_hit  = (AD[15:8] == IO_PAGE);
    assign ram_hit = !io_hit && ((AD >> RAM_AW) == 16'd0);
    assign rd_acc  = rdy && !WE;
    assign wr_acc  = rdy && WE;

    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_io_wr
            assign io_wr[gi] = wr_acc && io_hit && (io_idx == 3'(gi));
        end
    endgenerate

    // ------------------------------------------------------------------
    // Byte RAM with registered read port
    // ------------------------------------------------------------------
    logic [7:0]        ram_mem [0:(1 << RAM_AW) - 1];
    logic [RAM_AW-1:0] ram_addr;
    logic [7:0]        ram_q;

    assign ram_addr = AD[RAM_AW-1:0];

    always_ff @(posedge clk) begin
        if (wr_acc && ram_hit) begin
            ram_mem[ram_addr] <= DO;
        end
        if (rd_acc && ram_hit) begin
            ram_q <= ram_mem[ram_addr];
        end
    end

    // ------------------------------------------------------------------
    // Timer, status and NMI state
    // ------------------------------------------------------------------
    logic [15:0]    count_reg,     count_next;
    logic [7:0]     reload_lo_reg, reload_lo_next;
    logic [7:0]     reload_hi_reg, reload_hi_next;
    logic           en_reg,        en_next;
    logic           irqen_reg,     irqen_next;
    logic           auto_reg,      auto_next;
    logic           nmisel_reg,    nmisel_next;
    logic           exp_reg,       exp_next;
    logic           irq_reg;
    logic           nmi_reg;
    logic [NCW-1:0] nmi_cnt_reg,   nmi_cnt_next;
    logic           expire;
    logic           nmi_trig;

    always_comb begin
        // A count of 0 while enabled behaves like 1; a CNTHI write on the same edge suppresses expiry.
        expire         = en_reg && (count_reg <= 16'd1) && !io_wr[1];

        count_next     = count_reg;
        reload_lo_next = reload_lo_reg;
        reload_hi_next = reload_hi_reg;
        if (io_wr[0]) begin
            reload_lo_next = DO;
        end
        if (io_wr[1]) begin
            reload_hi_next = DO;
            count_next     = {DO, reload_lo_reg};
        end else if (en_reg) begin
            if (expire) begin
                count_next = auto_reg ? {reload_hi_reg, reload_lo_reg} : 16'd0;
            end else begin
                count_next = count_reg - 16'd1;
            end
        end

        en_next     = en_reg;
        irqen_next  = irqen_reg;
        auto_next   = auto_reg;
        nmisel_next = nmisel_reg;
        if (io_wr[2]) begin
            en_next     = DO[0];
            irqen_next  = DO[1];
            auto_next   = DO[2];
            nmisel_next = DO[3];
        end else if (expire && !auto_reg) begin
            en_next = 1'b0;
        end

        exp_next = exp_reg;
        if (io_wr[3] && DO[0]) begin
            exp_next = 1'b0;
        end
        if (expire) begin
            exp_next = 1'b1;
        end

        nmi_trig = io_wr[4] || (expire && nmisel_reg);
        if (nmi_trig) begin
            nmi_cnt_next = NCW'(NMI_LEN);
        end else if (nmi_cnt_reg != '0) begin
            nmi_cnt_next = nmi_cnt_reg - NCW'(1);
        end else begin
            nmi_cnt_next = nmi_cnt_reg;
        end
    end

    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            count_reg     <= 16'd0;
            reload_lo_reg <= 8'd0;
            reload_hi_reg <= 8'd0;
            en_reg        <= 1'b0;
            irqen_reg     <= 1'b0;
            auto_reg      <= 1'b0;
            nmisel_reg    <= 1'b0;
            exp_reg       <= 1'b0;
            irq_reg       <= 1'b0;
            nmi_reg       <= 1'b0;
            nmi_cnt_reg   <= '0;
        end else begin
            count_reg     <= count_next;
            reload_lo_reg <= reload_lo_next;
            reload_hi_reg <= reload_hi_next;
            en_reg        <= en_next;
            irqen_reg     <= irqen_next;
            auto_reg      <= auto_next;
            nmisel_reg    <= nmisel_next;
            exp_reg       <= exp_next;
            irq_reg       <= exp_next && irqen_next;
            nmi_reg       <= (nmi_cnt_next != '0);
            nmi_cnt_reg   <= nmi_cnt_next;
        end
    end

    // ------------------------------------------------------------------
    // Read data path
    // ------------------------------------------------------------------
    always_comb begin
        io_rdata = 8'h00;
        case (io_idx)
            3'd0:    io_rdata = count_reg[7:0];
            3'd1:    io_rdata = count_reg[15:8];
            3'd2:    io_rdata = {4'b0000, nmisel_reg, auto_reg, irqen_reg, en_reg};
            3'd3:    io_rdata = {7'b0000000, exp_reg};
            default: io_rdata = 8'h00;
        endcase
    end

    logic       di_ram_reg;
    logic [7:0] di_io_reg;

    // DI selects between the RAM output register and the I/O/unmapped register,
    // so the RAM read stays a plain block-RAM output with one cycle of latency.
    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            di_ram_reg <= 1'b0;
            di_io_reg  <= 8'h00;
        end else if (rd_acc) begin
            di_ram_reg <= ram_hit;
            di_io_reg  <= io_hit ? io_rdata : 8'hFF;
        end
    end

    assign DI  = di_ram_reg ? ram_q : di_io_reg;
    assign IRQ = irq_reg;
    assign NMI = nmi_reg;
    assign RDY = rdy;

    // ------------------------------------------------------------------
    // Wait-state generation
    // ------------------------------------------------------------------
`ifdef WAIT_STATES_EN
    localparam int unsigned WCW = (IO_WAIT > 1) ? $clog2(IO_WAIT) : 1;

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_t;

    state_t         state_reg;
    logic [WCW-1:0] wait_cnt_reg;
    logic           rdy_reg;

    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            state_reg    <= ST_IDLE;
            wait_cnt_reg <= '0;
            rdy_reg      <= 1'b1;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (rd_acc && io_hit && (IO_WAIT > 0)) begin
                        state_reg    <= ST_WAIT;
                        rdy_reg      <= 1'b0;
                        wait_cnt_reg <= WCW'(IO_WAIT - 1);
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt_reg == '0) begin
                        state_reg <= ST_IDLE;
                        rdy_reg   <= 1'b1;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg - WCW'(1);
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    rdy_reg   <= 1'b1;
                end
            endcase
        end
    end

    assign rdy = rdy_reg;
`else
    // No stalls in this build: IO_WAIT has no effect on RDY.
    assign rdy = 1'b1 || (IO_WAIT != 0);
`endif

endmodule
